// File: rtl/mem_access_unit_if.sv
// Signal bundle between the MEM pipeline stage, the memory access unit and data memory.
// The unit itself connects through the slave modport. The master modport is the
// surrounding pipeline/memory environment.
interface mem_access_unit_if;
    // Pipeline side
    logic [31:0] MEM_ALU_OUT;
    logic [31:0] MEM_WRITE_DATA;
    logic        MEM_DATA_MEM_READ;
    logic        MEM_DATA_MEM_WRITE;
    logic [2:0]  MEM_FUNC3;
    logic [31:0] MEM_DATA_MEM_READ_DATA;
    logic        MEM_STALL;
    logic        MEM_MISALIGNED;
    // Data memory side
    logic [31:0] DMEM_ADDR;
    logic [31:0] DMEM_WRITE_DATA;
    logic [3:0]  DMEM_BYTE_EN;
    logic        DMEM_READ;
    logic        DMEM_WRITE;
    logic [31:0] DMEM_READ_DATA;
    logic        DMEM_BUSYWAIT;

    modport master (
        output MEM_ALU_OUT, MEM_WRITE_DATA, MEM_DATA_MEM_READ, MEM_DATA_MEM_WRITE, MEM_FUNC3,
               DMEM_READ_DATA, DMEM_BUSYWAIT,
        input  MEM_DATA_MEM_READ_DATA, MEM_STALL, MEM_MISALIGNED,
               DMEM_ADDR, DMEM_WRITE_DATA, DMEM_BYTE_EN, DMEM_READ, DMEM_WRITE
    );

    modport slave (
        input  MEM_ALU_OUT, MEM_WRITE_DATA, MEM_DATA_MEM_READ, MEM_DATA_MEM_WRITE, MEM_FUNC3,
               DMEM_READ_DATA, DMEM_BUSYWAIT,
        output MEM_DATA_MEM_READ_DATA, MEM_STALL, MEM_MISALIGNED,
               DMEM_ADDR, DMEM_WRITE_DATA, DMEM_BYTE_EN, DMEM_READ, DMEM_WRITE
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit: turns MEM-stage load/store requests into registered data-memory
// transactions (IDLE -> ACCESS -> DONE). It also formats store lanes and aligns and
// extends load data. The pipeline is stalled until the access completes.
// Optional build macro MISALIGNED_EXCEPTION_EN: misaligned half/word accesses skip memory
// and pulse MEM_MISALIGNED. When the macro is undefined they are silently aligned.
module mem_access_unit (
    input  logic             CLK,
    input  logic             RESET,
    mem_access_unit_if.slave bus
);

`ifdef MISALIGNED_EXCEPTION_EN
    localparam bit MisalignedEn = 1'b1;
`else
    localparam bit MisalignedEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        mis_q, mis_d;
    logic [2:0]  func3_q, func3_d;
    logic [1:0]  off_q, off_d;

    logic        req;
    logic        misaligned;
    logic [1:0]  off;
    logic [3:0]  be_fmt;
    logic [31:0] wdata_fmt;
    logic [31:0] load_fmt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign req = bus.MEM_DATA_MEM_READ | bus.MEM_DATA_MEM_WRITE;
    assign off = bus.MEM_ALU_OUT[1:0];

    // Halfword codes have func3[1:0]==01. Everything with func3[1] set, including
    // unsupported codes, is treated as a word access.
    assign misaligned = MisalignedEn &&
        (((bus.MEM_FUNC3[1:0] == 2'b01) && off[0]) || (bus.MEM_FUNC3[1] && (off != 2'b00)));

    // Store lane formatting. A halfword uses addr[1] only, so addr[0] is ignored.
    always_comb begin
        be_fmt    = 4'b1111;
        wdata_fmt = bus.MEM_WRITE_DATA;
        case (bus.MEM_FUNC3[1:0])
            2'b00: begin
                be_fmt    = 4'b0001 << off;
                wdata_fmt = {4{bus.MEM_WRITE_DATA[7:0]}};
            end
            2'b01: begin
                be_fmt    = 4'b0011 << {off[1], 1'b0};
                wdata_fmt = {2{bus.MEM_WRITE_DATA[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_byte = bus.DMEM_READ_DATA[{off_q, 3'b000} +: 8];
    assign ld_half = off_q[1] ? bus.DMEM_READ_DATA[31:16] : bus.DMEM_READ_DATA[15:0];

    // Load lane selection and extension, using the func3 and offset latched at request time.
    always_comb begin
        load_fmt = bus.DMEM_READ_DATA;
        case (func3_q)
            3'b000:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_fmt = {24'h0, ld_byte};
            3'b101:  load_fmt = {16'h0, ld_half};
            default: load_fmt = bus.DMEM_READ_DATA;
        endcase
    end

    // Next-state logic for the FSM and for every registered output.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        mis_d   = mis_q;
        func3_d = func3_q;
        off_d   = off_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = {bus.MEM_ALU_OUT[31:2], 2'b00};
                    be_d    = be_fmt;
                    wdata_d = wdata_fmt;
                    func3_d = bus.MEM_FUNC3;
                    off_d   = off;
                    if (misaligned) begin
                        state_d = StDone;
                        mis_d   = 1'b1;
                        if (bus.MEM_DATA_MEM_READ) begin
                            rdata_d = 32'h0;
                        end
                    end else begin
                        state_d = StAccess;
                        // A read wins when both read and write are requested.
                        rd_d    = bus.MEM_DATA_MEM_READ;
                        wr_d    = ~bus.MEM_DATA_MEM_READ;
                    end
                end
            end
            StAccess: begin
                if (!bus.DMEM_BUSYWAIT) begin
                    state_d = StDone;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (rd_q) begin
                        rdata_d = load_fmt;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                mis_d   = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers. Reset abandons any access in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            be_q    <= 4'h0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            func3_q <= 3'h0;
            off_q   <= 2'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            mis_q   <= mis_d;
            func3_q <= func3_d;
            off_q   <= off_d;
        end
    end

    assign bus.DMEM_ADDR              = addr_q;
    assign bus.DMEM_WRITE_DATA        = wdata_q;
    assign bus.DMEM_BYTE_EN           = be_q;
    assign bus.DMEM_READ              = rd_q;
    assign bus.DMEM_WRITE             = wr_q;
    assign bus.MEM_DATA_MEM_READ_DATA = rdata_q;
    assign bus.MEM_MISALIGNED         = mis_q;
    // Stall drops during reset so that a held request does not keep the pipeline frozen.
    assign bus.MEM_STALL              = RESET && req && (state_q != StDone);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. The driver pushes model expectations into
// queues, and a negedge monitor pops them when the DUT strobes memory or completes.
module tb_mem_access_unit;

`ifdef MISALIGNED_EXCEPTION_EN
    localparam bit MisEn = 1'b1;
`else
    localparam bit MisEn = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          rd;
        bit          wr;
        int          ncyc;
    } strobe_t;

    typedef struct {
        logic [31:0] data;
        bit          mis;
    } result_t;

    logic CLK = 1'b0;
    logic RESET;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    strobe_t     strobe_q[$];
    result_t     res_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          busy_n = 0;
    int          acc_cnt = 0;
    logic [31:0] mem_word = 32'h0;
    logic [31:0] last_load = 32'h0;
    logic [2:0]  load_tbl[6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference model: access size/sign from func3, lanes via shifts and arithmetic.
    function automatic void model(input bit rd, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  input int busy, output strobe_t s, output result_t r,
                                  output int stalls);
        int          off, hoff, size;
        bit          sext;
        logic [31:0] v;
        off  = int'(addr % 4);
        hoff = off - (off % 2);
        case (f3)
            3'b000:  begin size = 1; sext = 1'b1; end
            3'b001:  begin size = 2; sext = 1'b1; end
            3'b100:  begin size = 1; sext = 1'b0; end
            3'b101:  begin size = 2; sext = 1'b0; end
            default: begin size = 4; sext = 1'b0; end
        endcase
        s.addr = addr & 32'hFFFF_FFFC;
        if (size == 1) begin
            s.be    = 4'(1 << off);
            s.wdata = (wdata & 32'hFF) * 32'h0101_0101;
        end else if (size == 2) begin
            s.be    = 4'(3 << hoff);
            s.wdata = (wdata & 32'hFFFF) * 32'h0001_0001;
        end else begin
            s.be    = 4'hF;
            s.wdata = wdata;
        end
        s.rd   = rd;
        s.wr   = !rd;
        s.ncyc = busy + 1;
        r.mis  = MisEn && ((size == 2 && (off % 2) != 0) || (size == 4 && off != 0));
        if (rd) begin
            if (size == 1) begin
                v = (rdata >> (8 * off)) & 32'hFF;
                if (sext && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
                v = (rdata >> (8 * hoff)) & 32'hFFFF;
                if (sext && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end else begin
                v = rdata;
            end
            r.data = r.mis ? 32'h0 : v;
        end else begin
            r.data = last_load;
        end
        stalls = r.mis ? 1 : busy + 2;
    endfunction

    // Issue one request and hold it until the stall drops (the completion cycle).
    task automatic txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int busy);
        strobe_t s;
        result_t r;
        int      exp_stalls;
        int      cnt;
        bit      done;
        model(rd, f3, addr, wdata, rdata, busy, s, r, exp_stalls);
        @(posedge CLK);
        #1;
        if (!r.mis) strobe_q.push_back(s);
        res_q.push_back(r);
        if (rd) last_load = r.data;
        busy_n                 = busy;
        mem_word               = rdata;
        bus.MEM_DATA_MEM_READ  = rd;
        bus.MEM_DATA_MEM_WRITE = wr;
        bus.MEM_FUNC3          = f3;
        bus.MEM_ALU_OUT        = addr;
        bus.MEM_WRITE_DATA     = wdata;
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge CLK);
            if (bus.MEM_STALL) cnt++;
            else done = 1'b1;
        end
        if (!done) fail_now("stall_timeout");
        else check("stall_cycles", cnt, exp_stalls);
    endtask

    task automatic idle(input int n);
        @(posedge CLK);
        #1;
        bus.MEM_DATA_MEM_READ  = 1'b0;
        bus.MEM_DATA_MEM_WRITE = 1'b0;
        bus.MEM_ALU_OUT        = $urandom;
        repeat (n) @(posedge CLK);
    endtask

    // Memory responder: busywait for busy_n ACCESS cycles, then real data. Outside an
    // access, busywait and read data are random, which the unit must ignore.
    initial begin
        bus.DMEM_BUSYWAIT  = 1'b0;
        bus.DMEM_READ_DATA = 32'h0;
        forever begin
            @(negedge CLK);
            if (RESET && (bus.DMEM_READ || bus.DMEM_WRITE)) begin
                if (acc_cnt < busy_n) begin
                    bus.DMEM_BUSYWAIT  = 1'b1;
                    bus.DMEM_READ_DATA = $urandom;
                end else begin
                    bus.DMEM_BUSYWAIT  = 1'b0;
                    bus.DMEM_READ_DATA = mem_word;
                end
                acc_cnt++;
            end else begin
                acc_cnt            = 0;
                bus.DMEM_BUSYWAIT  = 1'($urandom_range(0, 1));
                bus.DMEM_READ_DATA = $urandom;
            end
        end
    end

    bit      mon_prev_stb = 1'b0;
    int      mon_stb_cyc = 0;
    strobe_t mon_se;
    result_t mon_re;

    // Monitor: compares strobes and completions against the queued expectations.
    initial begin
        forever begin
            @(negedge CLK);
            if (RESET !== 1'b1) begin
                mon_prev_stb = 1'b0;
                mon_stb_cyc  = 0;
            end else begin
                if (bus.DMEM_READ || bus.DMEM_WRITE) begin
                    if (strobe_q.size() == 0) begin
                        fail_now("unexpected_strobe");
                    end else begin
                        mon_se = strobe_q[0];
                        check("dmem_addr", bus.DMEM_ADDR, mon_se.addr);
                        check("dmem_read", 32'(bus.DMEM_READ), 32'(mon_se.rd));
                        check("dmem_write", 32'(bus.DMEM_WRITE), 32'(mon_se.wr));
                        if (mon_se.wr) begin
                            check("dmem_byte_en", 32'(bus.DMEM_BYTE_EN), 32'(mon_se.be));
                            check("dmem_write_data", bus.DMEM_WRITE_DATA, mon_se.wdata);
                        end
                    end
                    mon_stb_cyc++;
                    mon_prev_stb = 1'b1;
                end else begin
                    if (mon_prev_stb && strobe_q.size() != 0) begin
                        mon_se = strobe_q.pop_front();
                        check("strobe_cycles", mon_stb_cyc, mon_se.ncyc);
                    end
                    mon_prev_stb = 1'b0;
                    mon_stb_cyc  = 0;
                end
                if ((bus.MEM_DATA_MEM_READ || bus.MEM_DATA_MEM_WRITE) && !bus.MEM_STALL) begin
                    if (res_q.size() == 0) begin
                        fail_now("unexpected_completion");
                    end else begin
                        mon_re = res_q.pop_front();
                        check("load_result", bus.MEM_DATA_MEM_READ_DATA, mon_re.data);
                        check("misaligned_flag", 32'(bus.MEM_MISALIGNED), 32'(mon_re.mis));
                    end
                    check("strobe_pending", strobe_q.size(), 0);
                end else begin
                    check("misaligned_idle", 32'(bus.MEM_MISALIGNED), 0);
                end
            end
        end
    end

    initial begin
        strobe_t rs;
        bit      seen;
        logic [2:0] f3;
        bit      rd, wr;
        RESET                  = 1'b0;
        bus.MEM_ALU_OUT        = 32'h0;
        bus.MEM_WRITE_DATA     = 32'h0;
        bus.MEM_DATA_MEM_READ  = 1'b0;
        bus.MEM_DATA_MEM_WRITE = 1'b0;
        bus.MEM_FUNC3          = 3'b010;
        #1;
        check("rst_dmem_addr", bus.DMEM_ADDR, 0);
        check("rst_dmem_wdata", bus.DMEM_WRITE_DATA, 0);
        check("rst_byte_en", 32'(bus.DMEM_BYTE_EN), 0);
        check("rst_dmem_read", 32'(bus.DMEM_READ), 0);
        check("rst_dmem_write", 32'(bus.DMEM_WRITE), 0);
        check("rst_result", bus.MEM_DATA_MEM_READ_DATA, 0);
        check("rst_misaligned", 32'(bus.MEM_MISALIGNED), 0);
        check("rst_stall", 32'(bus.MEM_STALL), 0);
        @(negedge CLK);
        RESET = 1'b1;

        // Reset in the middle of a long LW access.
        @(posedge CLK);
        #1;
        rs.addr = 32'h40; rs.be = 4'hF; rs.wdata = 32'h0; rs.rd = 1'b1; rs.wr = 1'b0;
        rs.ncyc = 1000;
        strobe_q.push_back(rs);
        busy_n                = 1000;
        mem_word              = 32'h1234_5678;
        bus.MEM_ALU_OUT       = 32'h40;
        bus.MEM_FUNC3         = 3'b010;
        bus.MEM_DATA_MEM_READ = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            if (bus.DMEM_READ) seen = 1'b1;
        end
        check("rst_test_strobe_seen", 32'(seen), 1);
        repeat (2) @(negedge CLK);
        check("pre_rst_stall", 32'(bus.MEM_STALL), 1);
        #2;
        RESET = 1'b0;
        #1;
        check("async_rst_dmem_read", 32'(bus.DMEM_READ), 0);
        check("async_rst_stall", 32'(bus.MEM_STALL), 0);
        check("async_rst_addr", bus.DMEM_ADDR, 0);
        check("async_rst_result", bus.MEM_DATA_MEM_READ_DATA, 0);
        strobe_q.delete();
        res_q.delete();
        @(posedge CLK);
        #1;
        bus.MEM_DATA_MEM_READ = 1'b0;
        @(negedge CLK);
        RESET  = 1'b1;
        busy_n = 0;
        repeat (2) @(negedge CLK);
        check("post_rst_result", bus.MEM_DATA_MEM_READ_DATA, 0);

        // LB at 0x103, sign-extended top byte.
        txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0);
        check("lb_result_const", bus.MEM_DATA_MEM_READ_DATA, 32'hFFFF_FF80);
        check("lb_addr_const", bus.DMEM_ADDR, 32'h100);
        idle(1);

        // SH at 0x202 with three busywait cycles.
        txn(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'hDEAD_BEEF, 3);
        check("sh_byte_en_const", 32'(bus.DMEM_BYTE_EN), 32'hC);
        check("sh_wdata_const", bus.DMEM_WRITE_DATA, 32'hABCD_ABCD);
        check("sh_keeps_result", bus.MEM_DATA_MEM_READ_DATA, 32'hFFFF_FF80);
        idle(0);

        // LHU then back-to-back LW.
        txn(1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h1234_F00D, 0);
        check("lhu_result_const", bus.MEM_DATA_MEM_READ_DATA, 32'h0000_F00D);
        txn(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 32'h5A5A_0101, 1);
        idle(1);

        // Misaligned word load.
        txn(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'hCAFE_BABE, 0);
`ifdef MISALIGNED_EXCEPTION_EN
        check("lw_misaligned_result", bus.MEM_DATA_MEM_READ_DATA, 32'h0);
`else
        check("lw_aligned_result", bus.MEM_DATA_MEM_READ_DATA, 32'hCAFE_BABE);
        check("lw_aligned_addr", bus.DMEM_ADDR, 32'h100);
`endif
        idle(1);

        // Read and write together is treated as a read.
        txn(1'b1, 1'b1, 3'b100, 32'h305, 32'hFFFF_FFFF, 32'h0011_8800, 2);
        idle(0);

        for (int k = 0; k < 200; k++) begin
            rd = 1'($urandom_range(0, 1));
            wr = !rd || ($urandom_range(0, 3) == 0);
            if (rd) f3 = load_tbl[$urandom_range(0, 5)];
            else f3 = 3'($urandom_range(0, 2));
            txn(rd, wr, f3, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 2)));
        end
        idle(3);
        check("result_queue_drained", res_q.size(), 0);
        check("strobe_queue_drained", strobe_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: CLK  in  1  pipeline clock, all state on rising edge.
REQ-002 SHALL have ports: RESET  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports: MEM_ALU_OUT  in  32  effective byte address from EX/MEM.
REQ-004 SHALL have ports: MEM_WRITE_DATA  in  32  store data (rs2).
REQ-005 SHALL have ports: MEM_DATA_MEM_READ / MEM_DATA_MEM_WRITE  in  1 each  load/store request.
REQ-006 SHALL have ports: MEM_FUNC3  in  3  access width/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have ports: DMEM_ADDR  out  32  word address ({addr[31:2],2'b00}); DMEM_WRITE_DATA  out  32; DMEM_BYTE_EN  out  4; DMEM_READ / DMEM_WRITE  out  1 each.
REQ-008 SHALL have ports: DMEM_READ_DATA  in  32; DMEM_BUSYWAIT  in  1  memory not ready.
REQ-009 SHALL have ports: MEM_DATA_MEM_READ_DATA  out  32  aligned, extended load result to MEM/WB; MEM_STALL  out  1  freeze PC/IF/ID/EX/MEM registers; MEM_MISALIGNED  out  1.

Function
REQ-010 SHALL implement FSM IDLE, ACCESS, DONE; state, DMEM_* outputs and MEM_DATA_MEM_READ_DATA registered.
REQ-011 IDLE: request (read or write) present -> ACCESS next edge, latching DMEM_ADDR, byte enables, write data, DMEM_READ/DMEM_WRITE.
REQ-012 ACCESS: DMEM_READ/DMEM_WRITE held stable; on edge with DMEM_BUSYWAIT=0 -> DONE, deassert DMEM_READ/WRITE, capture formatted load data.
REQ-013 DONE: exactly one cycle, -> IDLE unconditionally; pipeline advances this cycle.
REQ-014 MEM_STALL SHALL be combinational: 1 when request present and state != DONE; 0 otherwise.
REQ-015 Minimum latency: request in cycle T0 -> DMEM strobe T1 -> result valid and stall low T2 (2 stall cycles); each extra busywait cycle adds one.
REQ-016 Read and write both asserted SHALL be treated as read; write ignored.
REQ-017 Loads: byte lane = addr[1:0], half lane = addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through; unsupported func3 -> word.
REQ-018 Stores: SB byte_en = 0001<<addr[1:0], data byte replicated x4; SH byte_en = 0011<<(2*addr[1]), half replicated x2; SW 1111.
REQ-019 MEM_DATA_MEM_READ_DATA SHALL hold last captured value until next load completes; stores do not modify it.
REQ-020 DMEM_BUSYWAIT in IDLE or DONE SHALL be ignored.

Reset
REQ-021 RESET=0 SHALL immediately (no clock) force state IDLE, DMEM_ADDR/DMEM_WRITE_DATA/MEM_DATA_MEM_READ_DATA=0, DMEM_BYTE_EN=0, DMEM_READ/DMEM_WRITE/MEM_MISALIGNED=0.
REQ-022 Reset during ACCESS SHALL abandon the transaction; no data captured, strobes dropped asynchronously.
REQ-023 After RESET returns to 1, first edge with request behaves as REQ-011.

Configuration
REQ-024 Macro MISALIGNED_EXCEPTION_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL skip ACCESS (IDLE->DONE, one stall cycle), issue no DMEM strobe, MEM_MISALIGNED=1 in DONE only, load result 0.
REQ-025 Macro undefined: misaligned halfword/word SHALL be forced aligned (addr[0] resp. addr[1:0] treated as 0); MEM_MISALIGNED tied 0.

Verification
REQ-026 LB addr 0x103, DMEM_READ_DATA 0x80FF_1234, busywait 0 -> DMEM_ADDR 0x100, stall 2 cycles, result 0xFFFF_FF80.
REQ-027 SH addr 0x202, data 0x0000_ABCD, busywait 3 cycles -> byte_en 1100, DMEM_WRITE_DATA 0xABCD_ABCD held 4 cycles, stall 5 cycles.
REQ-028 LHU addr 0x10 data 0x1234_F00D -> 0x0000_F00D; next-cycle LW back-to-back -> separate IDLE->ACCESS->DONE sequence.
REQ-029 RESET=0 mid-ACCESS (LW busywait high) -> strobes and stall drop without clock; result stays 0.
REQ-030 LW addr 0x102 -> with MISALIGNED_EXCEPTION_EN: no strobe, 1 stall cycle, MEM_MISALIGNED pulse; without: DMEM_ADDR 0x100, normal load.
